// File: rtl/ipif_regs_pkg.sv
// ipif_regs_pkg: shared FSM encoding and sizing helpers for ipif_regs_v2
package ipif_regs_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;
  function automatic int log2c(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int max1(input int n);
    return (n < 1) ? 1 : n;
  endfunction
  function automatic int idx_width(input int total);
    return max1(log2c(total));
  endfunction
endpackage

// File: rtl/ipif_be_merge.sv
// ipif_be_merge: byte-enable merge of old/new words plus the W1C clear mask
module ipif_be_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   i_old,
  input  logic [DW-1:0]   i_new,
  input  logic [DW/8-1:0] i_be,
  output logic [DW-1:0]   o_merged,
  output logic [DW-1:0]   o_clr
);
  logic [DW-1:0] w_mask;
  for (genvar b = 0; b < DW/8; b++) begin : g_lane
    assign w_mask[8*b +: 8] = {8{i_be[b]}};
  end
  assign o_merged = (i_new & w_mask) | (i_old & ~w_mask);
  assign o_clr    = i_new & w_mask;
endmodule

// File: rtl/ipif_regs_v2.sv
// ipif_regs_v2: IPIF slave register file (WO, RW, W1C, RO); define IPIF_REGS_SNAPSHOT_EN for coherent RO snapshot reads
module ipif_regs_v2
  import ipif_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_WO_REGS        = 1,
  parameter int NUM_RW_REGS        = 1,
  parameter int NUM_W1C_REGS       = 1,
  parameter int NUM_RO_REGS        = 1
) (
  input  logic                                                Bus2IP_Clk,
  input  logic                                                Bus2IP_Reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                       Bus2IP_Addr,
  input  logic                                                Bus2IP_CS,
  input  logic                                                Bus2IP_RNW,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                       Bus2IP_Data,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                     Bus2IP_BE,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                       IP2Bus_Data,
  output logic                                                IP2Bus_RdAck,
  output logic                                                IP2Bus_WrAck,
  output logic                                                IP2Bus_Error,
  output logic [max1(NUM_WO_REGS)*C_S_AXI_DATA_WIDTH-1:0]     wo_regs,
  input  logic [max1(NUM_WO_REGS)*C_S_AXI_DATA_WIDTH-1:0]     wo_defaults,
  output logic [max1(NUM_RW_REGS)*C_S_AXI_DATA_WIDTH-1:0]     rw_regs,
  input  logic [max1(NUM_RW_REGS)*C_S_AXI_DATA_WIDTH-1:0]     rw_defaults,
  output logic [max1(NUM_WO_REGS+NUM_RW_REGS)-1:0]            wr_strobe,
  input  logic [max1(NUM_W1C_REGS)*C_S_AXI_DATA_WIDTH-1:0]    w1c_set,
  output logic [max1(NUM_W1C_REGS)*C_S_AXI_DATA_WIDTH-1:0]    w1c_regs,
  input  logic [max1(NUM_RO_REGS)*C_S_AXI_DATA_WIDTH-1:0]     ro_regs
);
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW_LSB   = log2c(DW/8);
  localparam int TOTAL    = NUM_WO_REGS + NUM_RW_REGS + NUM_W1C_REGS + NUM_RO_REGS;
  localparam int IDX_W    = idx_width(TOTAL);
  localparam int RW_BASE  = NUM_WO_REGS;
  localparam int W1C_BASE = RW_BASE + NUM_RW_REGS;
  localparam int RO_BASE  = W1C_BASE + NUM_W1C_REGS;
  state_t                               r_state;
  logic [max1(NUM_WO_REGS)*DW-1:0]      r_wo;
  logic [max1(NUM_RW_REGS)*DW-1:0]      r_rw;
  logic [max1(NUM_W1C_REGS)*DW-1:0]     r_w1c;
  logic [max1(NUM_WO_REGS+NUM_RW_REGS)-1:0] r_strobe;
  logic                                 r_rdack, r_wrack, r_err;
  logic [DW-1:0]                        r_data;
  logic [31:0]                          w_i;
  logic                                 w_go, w_wr, w_wo, w_rw, w_w1c, w_ro, w_err;
  logic [DW-1:0]                        w_old, w_merged, w_clr, w_rd;
  logic [max1(NUM_W1C_REGS)*DW-1:0]     w_clr_all;
  logic                                 w_unused;
  assign w_unused = ^Bus2IP_Addr;
  assign w_i      = 32'(Bus2IP_Addr[AW_LSB +: IDX_W]);
  assign w_wo     = w_i < RW_BASE;
  assign w_rw     = w_i >= RW_BASE && w_i < W1C_BASE;
  assign w_w1c    = w_i >= W1C_BASE && w_i < RO_BASE;
  assign w_ro     = w_i >= RO_BASE && w_i < TOTAL;
  assign w_go     = r_state == S_IDLE && Bus2IP_CS;
  assign w_wr     = w_go && !Bus2IP_RNW;
  assign w_err    = Bus2IP_RNW ? !(w_rw || w_w1c || w_ro) : !(w_wo || w_rw || w_w1c);
  ipif_be_merge #(.DW(DW)) u_merge (
    .i_old   (w_old),
    .i_new   (Bus2IP_Data),
    .i_be    (Bus2IP_BE),
    .o_merged(w_merged),
    .o_clr   (w_clr)
  );
`ifdef IPIF_REGS_SNAPSHOT_EN
  logic [max1(NUM_RO_REGS)*DW-1:0] r_snap;
  // A read of RO[0] freezes every RO word so later words read coherently
  always_ff @(posedge Bus2IP_Clk)
    if (Bus2IP_Reset) r_snap <= '0;
    else if (w_go && Bus2IP_RNW && NUM_RO_REGS > 0 && w_i == RO_BASE) r_snap <= ro_regs;
`endif
  always_comb begin
    w_old = '0;
    w_rd  = '0;
    for (int i = 0; i < NUM_WO_REGS; i++) if (w_i == i) w_old = r_wo[DW*i +: DW];
    for (int i = 0; i < NUM_RW_REGS; i++)
      if (w_i == RW_BASE + i) begin
        w_old = r_rw[DW*i +: DW];
        w_rd  = r_rw[DW*i +: DW];
      end
    for (int i = 0; i < NUM_W1C_REGS; i++) if (w_i == W1C_BASE + i) w_rd = r_w1c[DW*i +: DW];
`ifdef IPIF_REGS_SNAPSHOT_EN
    for (int i = 0; i < NUM_RO_REGS; i++)
      if (w_i == RO_BASE + i) w_rd = (i == 0) ? ro_regs[DW*i +: DW] : r_snap[DW*i +: DW];
`else
    for (int i = 0; i < NUM_RO_REGS; i++) if (w_i == RO_BASE + i) w_rd = ro_regs[DW*i +: DW];
`endif
  end
  always_comb begin
    w_clr_all = '0;
    for (int i = 0; i < NUM_W1C_REGS; i++)
      if (w_wr && w_i == W1C_BASE + i) w_clr_all[DW*i +: DW] = w_clr;
  end
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      r_state  <= S_IDLE;
      r_rdack  <= 1'b0;
      r_wrack  <= 1'b0;
      r_err    <= 1'b0;
      r_data   <= '0;
      r_strobe <= '0;
      r_wo     <= (NUM_WO_REGS > 0) ? wo_defaults : '0;
      r_rw     <= (NUM_RW_REGS > 0) ? rw_defaults : '0;
      r_w1c    <= '0;
    end else begin
      r_state  <= (r_state == S_IDLE) ? (Bus2IP_CS ? S_ACK : S_IDLE) :
                  (r_state == S_ACK)  ? S_HOLD : (Bus2IP_CS ? S_HOLD : S_IDLE);
      r_rdack  <= w_go && Bus2IP_RNW;
      r_wrack  <= w_go && !Bus2IP_RNW;
      r_err    <= w_go && w_err;
      r_data   <= (w_go && Bus2IP_RNW) ? w_rd : '0;
      r_strobe <= '0;
      // Hardware set is OR-ed after the clear so it wins on a collision
      r_w1c    <= (r_w1c & ~w_clr_all) | ((NUM_W1C_REGS > 0) ? w1c_set : '0);
      for (int i = 0; i < NUM_WO_REGS; i++)
        if (w_wr && w_i == i) begin
          r_wo[DW*i +: DW] <= w_merged;
          r_strobe[i]      <= 1'b1;
        end
      for (int i = 0; i < NUM_RW_REGS; i++)
        if (w_wr && w_i == RW_BASE + i) begin
          r_rw[DW*i +: DW]           <= w_merged;
          r_strobe[NUM_WO_REGS + i]  <= 1'b1;
        end
    end
  end
  assign IP2Bus_Data  = r_data;
  assign IP2Bus_RdAck = r_rdack;
  assign IP2Bus_WrAck = r_wrack;
  assign IP2Bus_Error = r_err;
  assign wo_regs      = r_wo;
  assign rw_regs      = r_rw;
  assign w1c_regs     = r_w1c;
  assign wr_strobe    = r_strobe;
endmodule

// File: tb/tb_ipif_regs_v2.sv
// tb_ipif_regs_v2: randomized self-checking bench for ipif_regs_v2 (1 WO, 1 RW, 1 W1C, 2 RO)
module tb_ipif_regs_v2;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, wdata = '0, rdata_o;
  logic        cs = 1'b0, rnw = 1'b0;
  logic [3:0]  be = '0;
  logic        rdack, wrack, err;
  logic [31:0] wo_regs, rw_regs, w1c_regs;
  logic [31:0] wo_def = 32'hA5A5_0001, rw_def = '0, w1c_set = '0;
  logic [63:0] ro_regs = '0;
  logic [1:0]  strobe;
  int          checks = 0, failures = 0;
  logic [31:0] m_wo, m_rw, m_w1c;
  logic [63:0] m_snap;
  always #5 clk = ~clk;
  ipif_regs_v2 #(
    .NUM_WO_REGS(1), .NUM_RW_REGS(1), .NUM_W1C_REGS(1), .NUM_RO_REGS(2)
  ) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Reset(rst), .Bus2IP_Addr(addr), .Bus2IP_CS(cs),
    .Bus2IP_RNW(rnw), .Bus2IP_Data(wdata), .Bus2IP_BE(be), .IP2Bus_Data(rdata_o),
    .IP2Bus_RdAck(rdack), .IP2Bus_WrAck(wrack), .IP2Bus_Error(err),
    .wo_regs(wo_regs), .wo_defaults(wo_def), .rw_regs(rw_regs), .rw_defaults(rw_def),
    .wr_strobe(strobe), .w1c_set(w1c_set), .w1c_regs(w1c_regs), .ro_regs(ro_regs)
  );
  function automatic logic [31:0] lane_write(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] b);
    logic [31:0] res;
    res = old;
    for (int k = 0; k < 4; k++) if (b[k]) res[8*k +: 8] = nw[8*k +: 8];
    return res;
  endfunction
  function automatic logic [31:0] lane_mask(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction
  function automatic logic [31:0] mk_addr(input int idx);
    return ($urandom & 32'hFFFF_FFE0) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
  endfunction
  // One complete handshake; lat=-1 if no ack within the budget
  task automatic bus(input logic r, input int idx, input logic [31:0] d, input logic [3:0] b,
                     output logic [31:0] rd, output logic e, output int lat,
                     output logic [1:0] stb, output logic kind_ok, output int stray);
    @(negedge clk);
    addr = mk_addr(idx); cs = 1'b1; rnw = r; wdata = d; be = b;
    lat = -1; rd = '0; e = 1'b0; stb = '0; kind_ok = 1'b0; stray = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (rdack || wrack) begin
        lat = k; rd = rdata_o; e = err; stb = strobe;
        kind_ok = r ? (rdack && !wrack) : (wrack && !rdack);
        break;
      end
    end
    cs = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rdack || wrack || err || rdata_o != 0 || strobe != 0) stray++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    m_wo = 32'hA5A5_0001; m_rw = '0; m_w1c = '0; m_snap = '0;
    checks++; if (wo_regs !== m_wo) begin failures++; $display("FAIL reset_wo got=%h exp=%h", wo_regs, m_wo); end
    checks++; if (rw_regs !== m_rw) begin failures++; $display("FAIL reset_rw got=%h exp=%h", rw_regs, m_rw); end
    checks++; if (w1c_regs !== 32'h0) begin failures++; $display("FAIL reset_w1c got=%h exp=0", w1c_regs); end
    checks++; if ({rdack, wrack, err, strobe} !== 5'b0 || rdata_o !== 32'h0) begin
      failures++; $display("FAIL reset_outs got=%b/%h exp=0/0", {rdack, wrack, err, strobe}, rdata_o);
    end
    rst = 1'b0;
  endtask
  task automatic test_rw_be();
    logic [31:0] rd; logic e, ok; int lat, stray; logic [1:0] stb;
    bus(1'b0, 1, 32'h1122_3344, 4'b0101, rd, e, lat, stb, ok, stray);
    m_rw = lane_write(m_rw, 32'h1122_3344, 4'b0101);
    checks++; if (lat !== 1 || !ok) begin failures++; $display("FAIL rw_wrack lat got=%0d ok=%b exp=1/1", lat, ok); end
    checks++; if (rw_regs !== 32'h0022_0044) begin failures++; $display("FAIL rw_be got=%h exp=00220044", rw_regs); end
    checks++; if (stb !== 2'b10 || e !== 1'b0) begin failures++; $display("FAIL rw_strobe got=%b err=%b exp=10/0", stb, e); end
    checks++; if (stray !== 0) begin failures++; $display("FAIL rw_stray got=%0d exp=0", stray); end
  endtask
  task automatic test_hold_cs();
    int acks, first;
    logic [31:0] rd;
    @(negedge clk);
    addr = mk_addr(1); rnw = 1'b1; cs = 1'b1; acks = 0; first = -1; rd = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (rdack) begin acks++; if (first < 0) begin first = k; rd = rdata_o; end end
    end
    checks++; if (acks !== 1 || first !== 1) begin failures++; $display("FAIL hold_one_ack got=%0d@%0d exp=1@1", acks, first); end
    checks++; if (rd !== m_rw) begin failures++; $display("FAIL hold_rdata got=%h exp=%h", rd, m_rw); end
    cs = 1'b0;
    repeat (2) @(negedge clk);
    cs = 1'b1; acks = 0;
    repeat (3) begin @(negedge clk); if (rdack) acks++; end
    cs = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (acks !== 1) begin failures++; $display("FAIL hold_reack got=%0d exp=1", acks); end
  endtask
  task automatic test_w1c();
    logic [31:0] rd; logic e, ok; int lat, stray; logic [1:0] stb;
    @(negedge clk); w1c_set = 32'h8;
    @(negedge clk); w1c_set = '0; m_w1c |= 32'h8;
    checks++; if (w1c_regs !== m_w1c) begin failures++; $display("FAIL w1c_set got=%h exp=%h", w1c_regs, m_w1c); end
    w1c_set = 32'h8;
    bus(1'b0, 2, 32'h8, 4'hF, rd, e, lat, stb, ok, stray);
    w1c_set = '0;
    checks++; if (w1c_regs[3] !== 1'b1 || e !== 1'b0 || lat !== 1) begin
      failures++; $display("FAIL w1c_set_wins got=%b err=%b lat=%0d exp=1/0/1", w1c_regs[3], e, lat);
    end
    bus(1'b0, 2, 32'h8, 4'hF, rd, e, lat, stb, ok, stray);
    m_w1c &= ~32'h8;
    checks++; if (w1c_regs !== m_w1c) begin failures++; $display("FAIL w1c_clear got=%h exp=%h", w1c_regs, m_w1c); end
  endtask
  task automatic test_errors();
    logic [31:0] rd; logic e, ok; int lat, stray; logic [1:0] stb;
    bus(1'b0, 3, $urandom, 4'hF, rd, e, lat, stb, ok, stray);
    checks++; if (e !== 1'b1 || !ok || lat !== 1 || stb !== 2'b00) begin
      failures++; $display("FAIL err_ro_write got=err%b ok%b lat%0d stb%b exp=1/1/1/00", e, ok, lat, stb);
    end
    checks++; if ({wo_regs, rw_regs, w1c_regs} !== {m_wo, m_rw, m_w1c}) begin
      failures++; $display("FAIL err_no_change got=%h_%h_%h exp=%h_%h_%h", wo_regs, rw_regs, w1c_regs, m_wo, m_rw, m_w1c);
    end
    bus(1'b1, 7, 32'h0, 4'h0, rd, e, lat, stb, ok, stray);
    checks++; if (e !== 1'b1 || rd !== 32'h0 || !ok) begin failures++; $display("FAIL err_oor_read got=err%b data%h exp=1/0", e, rd); end
    bus(1'b1, 0, 32'h0, 4'hF, rd, e, lat, stb, ok, stray);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL err_wo_read got=err%b data%h exp=1/0", e, rd); end
    bus(1'b0, 5, $urandom, 4'hF, rd, e, lat, stb, ok, stray);
    checks++; if (e !== 1'b1 || {wo_regs, rw_regs, w1c_regs} !== {m_wo, m_rw, m_w1c}) begin
      failures++; $display("FAIL err_oor_write got=err%b exp=1 with no change", e);
    end
  endtask
  task automatic test_snapshot();
    logic [31:0] rd; logic e, ok; int lat, stray; logic [1:0] stb;
    logic [31:0] exp1;
    ro_regs = {32'd7, 32'h0000_1234};
    bus(1'b1, 3, 32'h0, 4'h0, rd, e, lat, stb, ok, stray);
    m_snap = ro_regs;
    checks++; if (rd !== 32'h1234 || e !== 1'b0) begin failures++; $display("FAIL snap_ro0 got=%h err=%b exp=1234/0", rd, e); end
    ro_regs[63:32] = 32'd9;
`ifdef IPIF_REGS_SNAPSHOT_EN
    exp1 = 32'd7;
`else
    exp1 = 32'd9;
`endif
    bus(1'b1, 4, 32'h0, 4'h0, rd, e, lat, stb, ok, stray);
    checks++; if (rd !== exp1 || e !== 1'b0) begin failures++; $display("FAIL snap_ro1 got=%h err=%b exp=%h/0", rd, e, exp1); end
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    rw_def = 32'h5A5A_0F0F; addr = mk_addr(1); rnw = 1'b1; cs = 1'b1; rst = 1'b1;
    @(negedge clk);
    m_wo = wo_def; m_rw = rw_def; m_w1c = '0; m_snap = '0;
    checks++; if (rdack !== 1'b0) begin failures++; $display("FAIL mid_reset_drop got=%b exp=0", rdack); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rdack !== 1'b1 || rdata_o !== m_rw) begin
      failures++; $display("FAIL mid_reset_new got=%b/%h exp=1/%h", rdack, rdata_o, m_rw);
    end
    cs = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_random();
    logic [31:0] rd, d, erd, sp; logic e, ok, r, eerr; int lat, stray, idx; logic [1:0] stb, estb; logic [3:0] b;
    for (int n = 0; n < 60; n++) begin
      ro_regs = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin
        sp = $urandom;
        @(negedge clk); w1c_set = sp;
        @(negedge clk); w1c_set = '0; m_w1c |= sp;
      end
      r = 1'($urandom_range(0, 1)); idx = $urandom_range(0, 7); d = $urandom; b = 4'($urandom);
      eerr = 1'b0; erd = '0; estb = '0;
      if (r) begin
        case (idx)
          1: erd = m_rw;
          2: erd = m_w1c;
          3: begin erd = ro_regs[31:0]; m_snap = ro_regs; end
`ifdef IPIF_REGS_SNAPSHOT_EN
          4: erd = m_snap[63:32];
`else
          4: erd = ro_regs[63:32];
`endif
          default: eerr = 1'b1;
        endcase
      end else begin
        case (idx)
          0: begin m_wo = lane_write(m_wo, d, b); estb = 2'b01; end
          1: begin m_rw = lane_write(m_rw, d, b); estb = 2'b10; end
          2: m_w1c &= ~(d & lane_mask(b));
          default: eerr = 1'b1;
        endcase
      end
      bus(r, idx, d, b, rd, e, lat, stb, ok, stray);
      checks++; if (lat !== 1 || !ok || stray !== 0) begin
        failures++; $display("FAIL rnd_handshake n=%0d got=lat%0d ok%b stray%0d exp=1/1/0", n, lat, ok, stray);
      end
      checks++; if (rd !== erd || e !== eerr || stb !== estb) begin
        failures++; $display("FAIL rnd_resp n=%0d idx=%0d got=%h/%b/%b exp=%h/%b/%b", n, idx, rd, e, stb, erd, eerr, estb);
      end
      checks++; if ({wo_regs, rw_regs, w1c_regs} !== {m_wo, m_rw, m_w1c}) begin
        failures++; $display("FAIL rnd_regs n=%0d got=%h_%h_%h exp=%h_%h_%h", n, wo_regs, rw_regs, w1c_regs, m_wo, m_rw, m_w1c);
      end
    end
  endtask
  initial begin
    test_reset();
    test_rw_be();
    test_hold_cs();
    test_w1c();
    test_errors();
    test_snapshot();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ipif_regs_v2.md
Name: ipif_regs_v2

Overview:
Parametrised IPIF slave register file, the successor to the current per-pcore register block. Address order is WO, then RW, then W1C status, then RO. New over the previous generation:
- byte-enable writes and per-register write strobes;
- sticky write-1-to-clear status registers set by hardware;
- error response on illegal accesses;
- a one-ack-per-chip-select handshake FSM.
Sits between the AXI-Lite IPIF shim and pcore datapath logic (arbiters, generators, monitors).

Parameters:
C_S_AXI_DATA_WIDTH, 32, bus data width; multiple of 8.
C_S_AXI_ADDR_WIDTH, 32, bus address width.
NUM_WO_REGS, 1, software-written, hardware-read registers.
NUM_RW_REGS, 1, software-written, hardware- and software-read registers.
NUM_W1C_REGS, 1, sticky status registers: hardware sets, software clears by writing 1.
NUM_RO_REGS, 1, hardware-driven, software-read registers.
(Each count is 0..64; packed port widths use max(N,1)*C_S_AXI_DATA_WIDTH.)

Ports:
Bus2IP_Clk  in  1  clock for all logic.
Bus2IP_Reset  in  1  synchronous, active-high reset.
Bus2IP_Addr  in  C_S_AXI_ADDR_WIDTH  byte address.
Bus2IP_CS  in  1  chip select; held high by IPIF until ack.
Bus2IP_RNW  in  1  1 = read, 0 = write.
Bus2IP_Data  in  C_S_AXI_DATA_WIDTH  write data.
Bus2IP_BE  in  C_S_AXI_DATA_WIDTH/8  byte enables.
IP2Bus_Data  out  C_S_AXI_DATA_WIDTH  read data.
IP2Bus_RdAck  out  1  read acknowledge pulse.
IP2Bus_WrAck  out  1  write acknowledge pulse.
IP2Bus_Error  out  1  error, qualified by an ack.
wo_regs  out  NUM_WO_REGS*DW  packed WO values; reg i at bits [DW*(i+1)-1:DW*i].
wo_defaults  in  NUM_WO_REGS*DW  WO reset values.
rw_regs  out  NUM_RW_REGS*DW  packed RW values.
rw_defaults  in  NUM_RW_REGS*DW  RW reset values.
wr_strobe  out  NUM_WO_REGS+NUM_RW_REGS  one-cycle pulse per WO/RW register written.
w1c_set  in  NUM_W1C_REGS*DW  hardware set pulses, per bit.
w1c_regs  out  NUM_W1C_REGS*DW  sticky status values.
ro_regs  in  NUM_RO_REGS*DW  hardware values.

Behaviour:
- Word index:
  - idx = Bus2IP_Addr[AW_LSB+IDX_W-1 : AW_LSB].
  - AW_LSB = log2(C_S_AXI_DATA_WIDTH/8).
  - IDX_W = log2(total register count), minimum 1.
  - Upper address bits are ignored.
- Region boundaries:
  - WO: [0, NWO).
  - RW: [NWO, NWO+NRW).
  - W1C: [NWO+NRW, NWO+NRW+NW1C).
  - RO: the following NRO indices.
  - idx at or beyond the total count is out of range.
- FSM, states IDLE, ACK, HOLD:
  - IDLE: CS=1 -> ACK; the access is performed on this edge.
  - ACK: exactly one cycle with RdAck or WrAck = 1 -> HOLD.
  - HOLD: waits for CS=0, then -> IDLE. Prevents a second ack while the IPIF deasserts CS late.
  - Latency: ack is asserted 1 cycle after CS is first sampled high.
- Writes:
  - WO/RW: byte lane b is updated only if BE[b]=1.
  - wr_strobe[idx] pulses during the ACK cycle.
  - W1C: bit k is cleared if BE lane of k=1 and Data[k]=1.
  - RO or out-of-range write: no state change; WrAck with Error=1.
- W1C hardware set: each cycle, w1c_regs |= w1c_set. On a simultaneous hardware set and software clear of the same bit, set wins.
- Reads:
  - RW, W1C and RO return their current value, sampled on the IDLE->ACK edge.
  - WO or out-of-range read returns 0 with Error=1.
  - BE is ignored on reads.
  - IP2Bus_Data is 0 outside the ACK cycle.
  - IP2Bus_Error = 0 outside the ACK cycle.
- Reset values:
  - FSM = IDLE.
  - All acks, Error, IP2Bus_Data and wr_strobe = 0.
  - WO/RW registers take their *_defaults values.
  - w1c_regs = 0.
- Reset mid-transaction: the pending ack is dropped and the FSM returns to IDLE. If CS is still high after reset, it is treated as a new access.
- A region with count 0 contributes no indices. Its packed output is a 1-word vector driven to 0.

Optional Feature:
IPIF_REGS_SNAPSHOT_EN: coherent multi-word RO reads.
- Defined:
  - A read of RO index 0 copies all ro_regs into a shadow array on the same edge, and returns the live RO[0].
  - Reads of RO[1..N-1] return the shadow values.
  - The shadow resets to 0.
- Undefined: all RO reads are live and no shadow array exists.

Decomposition:
Shared package ipif_regs_pkg:
- FSM state encoding (IDLE/ACK/HOLD);
- log2 function;
- region base/limit constant computation.
One natural sub-module, ipif_be_merge: combinational byte-enable merge of old/new data, plus the W1C clear mask.

Test Plan:
1. Reset with wo_defaults=32'hA5A5_0001 -> wo_regs=32'hA5A5_0001, w1c_regs=0, all acks 0.
2. Write RW[0] (idx 1, NWO=1) Data=32'h1122_3344, BE=4'b0101 over a default of 0 -> rw_regs=32'h0022_0044; WrAck 1 cycle after CS; wr_strobe[1] pulses once.
3. Hold CS high 5 cycles on one read -> exactly one RdAck, no second ack until CS drops and rises again.
4. w1c_set bit3 pulse; then write 32'h8, with w1c_set bit3=1 on the same cycle -> bit3 stays 1; next write of 32'h8 with no set -> bit3=0.
5. Write to an RO idx, and read idx=total+2 -> ack with Error=1, data 0, no register change.
6. With IPIF_REGS_SNAPSHOT_EN: read RO[0], change ro_regs[1] from 7 to 9, read RO[1] -> returns 7.
